// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register for the ARM-subset 5-stage core.
// Supports stall, bubble insertion, sync reset and per-slot valid.
module id_ex_stage_reg #(
  parameter int WORD     = 32,
  parameter int REG_ADDR = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                flush,
  input  logic                valid_in,
  input  logic [WORD-1:0]     pc_in,
  input  logic [WORD-1:0]     val_rn_in,
  input  logic [WORD-1:0]     val_rm_in,
  input  logic [11:0]         shift_operand_in,
  input  logic                imm_in,
  input  logic [23:0]         signed_imm_24_in,
  input  logic [3:0]          exe_cmd_in,
  input  logic                mem_r_en_in,
  input  logic                mem_w_en_in,
  input  logic                wb_en_in,
  input  logic                b_in,
  input  logic                s_in,
  input  logic [REG_ADDR-1:0] dest_in,
  input  logic [REG_ADDR-1:0] src1_in,
  input  logic [REG_ADDR-1:0] src2_in,
  input  logic [3:0]          status_in,
  output logic                valid_out,
  output logic [WORD-1:0]     pc_out,
  output logic [WORD-1:0]     val_rn_out,
  output logic [WORD-1:0]     val_rm_out,
  output logic [11:0]         shift_operand_out,
  output logic                imm_out,
  output logic [23:0]         signed_imm_24_out,
  output logic [3:0]          exe_cmd_out,
  output logic                mem_r_en_out,
  output logic                mem_w_en_out,
  output logic                wb_en_out,
  output logic                b_out,
  output logic                s_out,
  output logic [REG_ADDR-1:0] dest_out,
  output logic [REG_ADDR-1:0] src1_out,
  output logic [REG_ADDR-1:0] src2_out,
  output logic [3:0]          status_out,
  output logic                ld_st_out
);

  // Slot update: reset/bubble clear all, stall holds, else capture.
  // Side-effect controls are gated by valid_in so a bubble stays inert.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_out         <= 1'b0;
      pc_out            <= '0;
      val_rn_out        <= '0;
      val_rm_out        <= '0;
      shift_operand_out <= '0;
      imm_out           <= 1'b0;
      signed_imm_24_out <= '0;
      exe_cmd_out       <= '0;
      mem_r_en_out      <= 1'b0;
      mem_w_en_out      <= 1'b0;
      wb_en_out         <= 1'b0;
      b_out             <= 1'b0;
      s_out             <= 1'b0;
      dest_out          <= '0;
      src1_out          <= '0;
      src2_out          <= '0;
      status_out        <= '0;
      ld_st_out         <= 1'b0;
    end else if (!freeze) begin
      valid_out         <= valid_in;
      pc_out            <= pc_in;
      val_rn_out        <= val_rn_in;
      val_rm_out        <= val_rm_in;
      shift_operand_out <= shift_operand_in;
      imm_out           <= imm_in;
      signed_imm_24_out <= signed_imm_24_in;
      exe_cmd_out       <= exe_cmd_in;
      mem_r_en_out      <= valid_in & mem_r_en_in;
      mem_w_en_out      <= valid_in & mem_w_en_in;
      wb_en_out         <= valid_in & wb_en_in;
      b_out             <= valid_in & b_in;
      s_out             <= valid_in & s_in;
      dest_out          <= dest_in;
      src1_out          <= src1_in;
      src2_out          <= src2_in;
      status_out        <= status_in;
      ld_st_out         <= valid_in & (mem_r_en_in | mem_w_en_in);
    end
  end

endmodule
